qtu_packet_scheduler: RTL
=========================

Name: qtu_packet_scheduler

Overview:
- Sequences the Q-table update unit (QTUtestMBNodeID) on behalf of the packet receive path.
- Buffers incoming packet headers (source ID, known CH, packet type) in a small FIFO and filters types the update unit must not see.
- Presents one header at a time on the update unit's f* inputs, issues a single-cycle enable and holds the inputs stable until the unit reports done.
- Recovers from a hung update with a watchdog; exposes status counters.

Parameters:
- WORD_WIDTH, 16, width of source ID / known CH fields and counters.
- FIFO_DEPTH, 4, header FIFO entries (power of two, >=2).
- ACCEPT_MASK, 8'b0010_0110, bit t set = packet type t forwarded (default: types 1, 2, 5).
- TIMEOUT, 255, max cycles in WAIT before abort (>=2).

Ports:
- clk  in  1  system clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- pkt_valid  in  1  header offered by receive path.
- pkt_ready  out  1  scheduler can take a header (= FIFO not full).
- pkt_source_id  in  WORD_WIDTH  sender node ID.
- pkt_known_ch  in  WORD_WIDTH  CH ID carried by packet.
- pkt_type  in  3  packet type.
- qtu_en  out  1  one-cycle start pulse to update unit.
- fSourceID  out  WORD_WIDTH  held source ID to update unit.
- fKnownCH  out  WORD_WIDTH  held known CH to update unit.
- fPacketType  out  3  held type to update unit.
- qtu_done  in  1  update unit completion.
- clear_err  in  1  synchronous clear of timeout_err.
- busy  out  1  FSM not IDLE or FIFO non-empty.
- timeout_err  out  1  sticky watchdog flag.
- drop_count  out  WORD_WIDTH  saturating count of filtered headers.
- update_count  out  WORD_WIDTH  saturating count of completed updates.

Behaviour:
- Reset (nrst low, async): FIFO empty, FSM IDLE, qtu_en=0, fSourceID=0, fKnownCH=0, fPacketType=0, timeout_err=0, both counters 0, watchdog 0, pkt_ready=1. Reset mid-update abandons it; no pulse after release until a new header is pushed.
- Handshake: transfer when pkt_valid && pkt_ready at a rising edge.
  - If ACCEPT_MASK[pkt_type]=1, the header is written to the FIFO tail.
  - Otherwise it is consumed but discarded; drop_count increments (saturates at all-ones).
- pkt_ready = !full; no same-cycle bypass when full. A pop and a push in the same cycle are both honoured when not full.
- FSM states:
  - IDLE: if FIFO non-empty, load head into fSourceID/fKnownCH/fPacketType and go ISSUE. Head is not popped yet.
  - ISSUE: qtu_en=1 for exactly this cycle; watchdog cleared; go WAIT.
  - WAIT:
    - qtu_done=1: pop head, update_count++ (saturating), go IDLE.
    - Else, watchdog == TIMEOUT-1: set timeout_err, pop head, go IDLE. update_count unchanged.
    - Else: watchdog++.
- Latency: a header pushed at edge N into an empty FIFO with FSM IDLE gives qtu_en high in cycle N+2 (IDLE at N+1, ISSUE at N+2). Back-to-back headers: the next ISSUE comes 2 cycles after the done cycle.
- f* outputs hold their value from the IDLE load until the next load, including after done.
- qtu_done outside WAIT is ignored. qtu_done in the same cycle as a watchdog expiry counts as completion (done wins; no error).
- timeout_err stays set until clear_err=1 or reset. If clear_err and a new timeout occur in the same cycle, the set wins.
- FIFO pointers wrap modulo FIFO_DEPTH. Occupancy counter width is log2(FIFO_DEPTH)+1.

Test Plan:
- Single data header: after reset, push id=1, CH=15, type=3'b101 → 2 cycles later qtu_en pulses 1 cycle with fSourceID=1, fKnownCH=15, fPacketType=5. Drive qtu_done 5 cycles later → update_count=1, busy=0, f* still 1/15/5.
- Back-to-back headers: push id=1 then id=17, type 5, on consecutive cycles → second qtu_en comes 2 cycles after first done with fSourceID=17. No pulse before done; update_count=2.
- Filter: push type 3'b011, then type 3'b000 → no qtu_en, drop_count=2, FIFO empty, pkt_ready stays 1.
- Full FIFO: hold qtu_done low with TIMEOUT large, push 5 headers → 4 accepted (1 in service + 3 queued, or 4 queued before ISSUE), pkt_ready=0, 5th held. Assert done → pkt_ready=1 next cycle, 5th accepted.
- Watchdog: TIMEOUT=8, never assert done → timeout_err set after 8 WAIT cycles, head popped, next header issued. clear_err → flag 0. Done in the expiry cycle → no error.
- Async reset mid-WAIT: drop nrst between clock edges → all outputs immediately at reset values; no qtu_en after release.

Source files
------------

// File: rtl/qtu_packet_scheduler.sv
// Packet-header scheduler for the Q-table update unit: filtered header FIFO,
// issue/wait sequencer with a watchdog, and saturating status counters.
module qtu_packet_scheduler #(
  parameter int         WORD_WIDTH  = 16,
  parameter int         FIFO_DEPTH  = 4,
  parameter logic [7:0] ACCEPT_MASK = 8'b0010_0110,
  parameter int         TIMEOUT     = 255
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  pkt_valid,
  output logic                  pkt_ready,
  input  logic [WORD_WIDTH-1:0] pkt_source_id,
  input  logic [WORD_WIDTH-1:0] pkt_known_ch,
  input  logic [2:0]            pkt_type,
  output logic                  qtu_en,
  output logic [WORD_WIDTH-1:0] fSourceID,
  output logic [WORD_WIDTH-1:0] fKnownCH,
  output logic [2:0]            fPacketType,
  input  logic                  qtu_done,
  input  logic                  clear_err,
  output logic                  busy,
  output logic                  timeout_err,
  output logic [WORD_WIDTH-1:0] drop_count,
  output logic [WORD_WIDTH-1:0] update_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int HDR_W = 2 * WORD_WIDTH + 3;
  localparam int WD_W  = $clog2(TIMEOUT);

  localparam logic [PTR_W-1:0]      PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]      CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [WD_W-1:0]       WD_ONE   = WD_W'(1);
  localparam logic [WD_W-1:0]       WD_ZERO  = WD_W'(0);
  localparam logic [WD_W-1:0]       WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [WORD_WIDTH-1:0] W_ONE    = WORD_WIDTH'(1);
  localparam logic [WORD_WIDTH-1:0] W_MAX    = {WORD_WIDTH{1'b1}};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2} state_t;

  state_t                  state_q, state_d;
  logic [HDR_W-1:0]        mem_q [FIFO_DEPTH];
  logic [HDR_W-1:0]        mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [WORD_WIDTH-1:0]   f_id_q, f_id_d, f_ch_q, f_ch_d;
  logic [2:0]              f_ty_q, f_ty_d;
  logic                    qtu_en_q, qtu_en_d;
  logic [WD_W-1:0]         wd_q, wd_d;
  logic                    err_q, err_d;
  logic [WORD_WIDTH-1:0]   drop_q, drop_d, upd_q, upd_d;
  logic                    full_s, push_s, drop_s, pop_s, set_err_s;

  assign full_s       = (count_q == CNT_FULL);
  assign pkt_ready    = !full_s;
  assign busy         = (state_q != S_IDLE) || (count_q != CNT_ZERO);
  assign qtu_en       = qtu_en_q;
  assign fSourceID    = f_id_q;
  assign fKnownCH     = f_ch_q;
  assign fPacketType  = f_ty_q;
  assign timeout_err  = err_q;
  assign drop_count   = drop_q;
  assign update_count = upd_q;

  // Next-state logic: sequencer, FIFO bookkeeping, watchdog and counters.
  always_comb begin
    state_d   = state_q;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    f_id_d    = f_id_q;
    f_ch_d    = f_ch_q;
    f_ty_d    = f_ty_q;
    qtu_en_d  = 1'b0;
    wd_d      = wd_q;
    upd_d     = upd_q;
    drop_d    = drop_q;
    pop_s     = 1'b0;
    set_err_s = 1'b0;
    push_s    = pkt_valid && !full_s && ACCEPT_MASK[pkt_type];
    drop_s    = pkt_valid && !full_s && !ACCEPT_MASK[pkt_type];

    case (state_q)
      S_IDLE: begin
        if (count_q != CNT_ZERO) begin
          {f_id_d, f_ch_d, f_ty_d} = mem_q[rd_ptr_q];
          state_d  = S_ISSUE;
          qtu_en_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        wd_d    = WD_ZERO;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Completion beats a watchdog expiry landing in the same cycle.
        if (qtu_done) begin
          pop_s   = 1'b1;
          upd_d   = (upd_q == W_MAX) ? upd_q : upd_q + W_ONE;
          state_d = S_IDLE;
        end else if (wd_q == WD_LAST) begin
          pop_s     = 1'b1;
          set_err_s = 1'b1;
          state_d   = S_IDLE;
        end else begin
          wd_d = wd_q + WD_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (set_err_s) begin
      err_d = 1'b1;
    end else if (clear_err) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end

    if (push_s) begin
      mem_d[wr_ptr_q] = {pkt_source_id, pkt_known_ch, pkt_type};
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    if (drop_s && (drop_q != W_MAX)) begin
      drop_d = drop_q + W_ONE;
    end else begin
      drop_d = drop_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= S_IDLE;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= {HDR_W{1'b0}};
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= CNT_ZERO;
      f_id_q   <= {WORD_WIDTH{1'b0}};
      f_ch_q   <= {WORD_WIDTH{1'b0}};
      f_ty_q   <= 3'b000;
      qtu_en_q <= 1'b0;
      wd_q     <= WD_ZERO;
      err_q    <= 1'b0;
      drop_q   <= {WORD_WIDTH{1'b0}};
      upd_q    <= {WORD_WIDTH{1'b0}};
    end else begin
      state_q  <= state_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      f_id_q   <= f_id_d;
      f_ch_q   <= f_ch_d;
      f_ty_q   <= f_ty_d;
      qtu_en_q <= qtu_en_d;
      wd_q     <= wd_d;
      err_q    <= err_d;
      drop_q   <= drop_d;
      upd_q    <= upd_d;
    end
  end

endmodule
